rv_iommu_hpm_evq: RTL and testbench
===================================

Name: rv_iommu_hpm_evq

Overview:
Event collection queue directly upstream of the IOMMU hardware performance monitor (HPM).
- Edge-detects the six level-type event indicators from the translation datapath.
- Snapshots the associated ID set (device_id, process_id, PSCID, GSCID) per detection cycle.
- Buffers entries in a small FIFO and presents them one per handshake to the HPM counting logic.
- Guarantees that back-to-back or simultaneous events with differing IDs are neither merged nor lost silently.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the dropped-entry counter (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- tr_request_i  in  1  level: untranslated request in flight.
- iotlb_miss_i  in  1  level: IOTLB miss.
- ddt_walk_i  in  1  level: DDT walk.
- pdt_walk_i  in  1  level: PDT walk.
- s1_ptw_i  in  1  level: first-stage page-table walk.
- s2_ptw_i  in  1  level: second-stage page-table walk.
- did_i  in  24  device_id of the current transaction.
- pid_i  in  20  process_id.
- pid_v_i  in  1  process_id valid.
- pscid_i  in  20  PSCID.
- gscid_i  in  16  GSCID.
- evt_valid_o  out  1  head entry valid.
- evt_ready_i  in  1  HPM accepts head entry.
- evt_mask_o  out  6  one-hot-or-more event mask; bit order {s2,s1,pdt,ddt,iotlb_miss,tr_req}.
- evt_did_o  out  24  head entry device_id.
- evt_pid_o  out  20  head entry process_id.
- evt_pid_v_o  out  1  head entry process_id valid.
- evt_pscid_o  out  20  head entry PSCID.
- evt_gscid_o  out  16  head entry GSCID.
- ovf_clr_i  in  1  clear sticky overflow flag.
- ovf_o  out  1  sticky: at least one entry dropped.
- level_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Edge detect: `prev_q[5:0]` registers the event vector every cycle. `rise = vec & ~prev_q`.
- Reset clears `prev_q`, so a level already high when reset deasserts counts as a new event.
- Push: when `rise != 0`, one entry is pushed holding `{rise, did_i, pid_i, pid_v_i, pscid_i, gscid_i}` sampled that cycle. Simultaneous rises share a single entry; the HPM counts every mask bit.
- Pop: occurs when `evt_valid_o & evt_ready_i`.
- Output is registered from FIFO storage. An event rising in cycle t appears on `evt_valid_o` in cycle t+1; minimum latency is 1 and there is no combinational input-to-output path.
- Output stability: while `evt_valid_o=1` and `evt_ready_i=0`, all `evt_*` outputs hold stable.
- Full with pop in the same cycle: push accepted. Level is unchanged and the pointers advance.
- Full without pop: the new entry is dropped, `ovf_o` is set the next cycle and `level_o` stays DEPTH.
- Empty: `evt_valid_o=0` and the `evt_*` data outputs are don't-care; implement them as the head storage value.
- Push into an empty FIFO: the entry is visible at t+1; no same-cycle bypass.
- `ovf_clr_i` together with a drop in the same cycle: set wins and `ovf_o` stays 1.
- Pointers: `$clog2(DEPTH)`-bit pointers wrap naturally. Full/empty are derived from the occupancy counter `level_o`, range 0..DEPTH.
- Reset mid-operation: pointers, level, `prev_q` and `ovf` are cleared to 0 next edge and pending entries are discarded.
- Reset values: `evt_valid_o=0`, `level_o=0`, `ovf_o=0`, `evt_mask_o=0`, all ID outputs 0. Storage is not reset.

Optional Feature:
- Macro: RV_IOMMU_HPM_EVQ_DROP_CNT_EN.
- With the macro defined: adds output port `drop_cnt_o [CNT_W-1:0]`, which counts dropped entries. It saturates at all-ones, clears on reset or `ovf_clr_i`, and a drop in the same cycle as `ovf_clr_i` yields 1.
- Without the macro: the port and counter are absent; only `ovf_o` is provided.

Decomposition:
- Shared package `rv_iommu` holds:
  - the `hpm_evt_idx_e` enum (bit positions 0..5 above);
  - the `hpm_evt_entry_t` packed struct (mask, did, pid, pid_v, pscid, gscid; 87 bits);
  - the `HPM_N_EVT = 6` constant.
- One natural sub-module: `rv_iommu_sync_fifo`, a generic synchronous FIFO parameterised on DEPTH and entry type, with push/pop/full/empty/level. The top level holds edge detect, drop logic and the counter.

Test Plan:
1. Reset, then assert `iotlb_miss_i` high for 5 cycles with `did_i=0x00A5A5` -> exactly one entry. `evt_valid_o=1` one cycle after the rise, `mask=6'b000010`, `did=0x00A5A5`; after pop `level_o=0`.
2. `s1_ptw_i` and `s2_ptw_i` rise in the same cycle, `gscid_i=0x1234` -> single entry with `mask=6'b110000`, `gscid=0x1234`.
3. With `evt_ready_i=0` and DEPTH=4, generate 5 distinct rises with `did` 1..5 -> `level_o=4`, `ovf_o=1`, `drop_cnt_o=1`. After releasing ready, the outputs show `did` 1,2,3,4 in order.
4. With the FIFO full, a rise and a pop occur in the same cycle -> no drop, `level_o` stays 4, the new entry appears last.
5. Hold `tr_request_i=1` across a 2-cycle `rst_i` pulse with 2 entries pending -> entries flushed, one new entry with `mask=6'b000001` one cycle after reset deasserts.
6. `ovf_o=1`, then pulse `ovf_clr_i` with no drop -> `ovf_o=0` and `drop_cnt_o=0` next cycle. Repeat with a coincident drop -> `ovf_o=1`, `drop_cnt_o=1`.

Source files
------------

// File: rtl/rv_iommu_pkg.sv
// rtl/rv_iommu_pkg.sv - shared IOMMU HPM event types and constants
package rv_iommu_pkg;

    localparam int HPM_N_EVT = 6;

    typedef enum logic [2:0] {
        HPM_EVT_TR_REQ     = 3'd0,
        HPM_EVT_IOTLB_MISS = 3'd1,
        HPM_EVT_DDT_WALK   = 3'd2,
        HPM_EVT_PDT_WALK   = 3'd3,
        HPM_EVT_S1_PTW     = 3'd4,
        HPM_EVT_S2_PTW     = 3'd5
    } hpm_evt_idx_e;

    typedef struct packed {
        logic [HPM_N_EVT-1:0] mask;
        logic [23:0]          did;
        logic [19:0]          pid;
        logic                 pid_v;
        logic [19:0]          pscid;
        logic [15:0]          gscid;
    } hpm_evt_entry_t;

endpackage

// File: rtl/rv_iommu_sync_fifo.sv
// rtl/rv_iommu_sync_fifo.sv - synchronous FIFO with registered head output
module rv_iommu_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T              mem_q [DEPTH];
    T              head_d, head_q;
    logic [AW-1:0] wr_ptr_d, wr_ptr_q;
    logic [AW-1:0] rd_ptr_d, rd_ptr_q;
    logic [LW-1:0] level_d, level_q;
    logic          push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // The head is re-registered from storage so data_o has no path from data_i
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
        if (push_ok || pop_ok) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = head_q;
    assign level_o = level_q;

endmodule

// File: rtl/rv_iommu_hpm_evq.sv
// rtl/rv_iommu_hpm_evq.sv - HPM event edge detect and queue; RV_IOMMU_HPM_EVQ_DROP_CNT_EN adds drop_cnt_o
module rv_iommu_hpm_evq
    import rv_iommu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tr_request_i,
    input  logic                   iotlb_miss_i,
    input  logic                   ddt_walk_i,
    input  logic                   pdt_walk_i,
    input  logic                   s1_ptw_i,
    input  logic                   s2_ptw_i,
    input  logic [23:0]            did_i,
    input  logic [19:0]            pid_i,
    input  logic                   pid_v_i,
    input  logic [19:0]            pscid_i,
    input  logic [15:0]            gscid_i,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [5:0]             evt_mask_o,
    output logic [23:0]            evt_did_o,
    output logic [19:0]            evt_pid_o,
    output logic                   evt_pid_v_o,
    output logic [19:0]            evt_pscid_o,
    output logic [15:0]            evt_gscid_o,
    input  logic                   ovf_clr_i,
    output logic                   ovf_o,
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    output logic [CNT_W-1:0]       drop_cnt_o,
`endif
    output logic [$clog2(DEPTH):0] level_o
);

    logic [HPM_N_EVT-1:0] vec, rise;
    logic [HPM_N_EVT-1:0] prev_d, prev_q;
    logic                 ovf_d, ovf_q;
    logic                 push_req, pop, full, empty, drop;
    hpm_evt_entry_t       in_entry, head;

    always_comb begin
        vec                     = '0;
        vec[HPM_EVT_TR_REQ]     = tr_request_i;
        vec[HPM_EVT_IOTLB_MISS] = iotlb_miss_i;
        vec[HPM_EVT_DDT_WALK]   = ddt_walk_i;
        vec[HPM_EVT_PDT_WALK]   = pdt_walk_i;
        vec[HPM_EVT_S1_PTW]     = s1_ptw_i;
        vec[HPM_EVT_S2_PTW]     = s2_ptw_i;
    end

    assign prev_d   = vec;
    assign rise     = vec & ~prev_q;
    assign push_req = (rise != '0);
    assign pop      = evt_valid_o & evt_ready_i;
    // A full queue only loses the entry when the HPM is not draining this cycle
    assign drop     = push_req & full & ~pop;
    assign ovf_d    = drop | (ovf_q & ~ovf_clr_i);

    always_comb begin
        in_entry       = '0;
        in_entry.mask  = rise;
        in_entry.did   = did_i;
        in_entry.pid   = pid_i;
        in_entry.pid_v = pid_v_i;
        in_entry.pscid = pscid_i;
        in_entry.gscid = gscid_i;
    end

    rv_iommu_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (hpm_evt_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .data_i  (in_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = ovf_clr_i ? '0 : cnt_q;
        if (drop && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt_o = cnt_q;
`endif

    assign evt_valid_o = ~empty;
    assign evt_mask_o  = head.mask;
    assign evt_did_o   = head.did;
    assign evt_pid_o   = head.pid;
    assign evt_pid_v_o = head.pid_v;
    assign evt_pscid_o = head.pscid;
    assign evt_gscid_o = head.gscid;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_rv_iommu_hpm_evq.sv
// tb/tb_rv_iommu_hpm_evq.sv - bench for rv_iommu_hpm_evq against a queue-based model
module tb_rv_iommu_hpm_evq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        tr_request_i = 0, iotlb_miss_i = 0, ddt_walk_i = 0;
    logic        pdt_walk_i = 0, s1_ptw_i = 0, s2_ptw_i = 0;
    logic [23:0] did_i = '0;
    logic [19:0] pid_i = '0;
    logic        pid_v_i = 1'b0;
    logic [19:0] pscid_i = '0;
    logic [15:0] gscid_i = '0;
    logic        evt_ready_i = 1'b0;
    logic        ovf_clr_i = 1'b0;
    logic        evt_valid_o;
    logic [5:0]  evt_mask_o;
    logic [23:0] evt_did_o;
    logic [19:0] evt_pid_o;
    logic        evt_pid_v_o;
    logic [19:0] evt_pscid_o;
    logic [15:0] evt_gscid_o;
    logic        ovf_o;
    logic [$clog2(DEPTH):0] level_o;
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_o;
`endif

    rv_iommu_hpm_evq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tr_request_i (tr_request_i),
        .iotlb_miss_i (iotlb_miss_i),
        .ddt_walk_i   (ddt_walk_i),
        .pdt_walk_i   (pdt_walk_i),
        .s1_ptw_i     (s1_ptw_i),
        .s2_ptw_i     (s2_ptw_i),
        .did_i        (did_i),
        .pid_i        (pid_i),
        .pid_v_i      (pid_v_i),
        .pscid_i      (pscid_i),
        .gscid_i      (gscid_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_mask_o   (evt_mask_o),
        .evt_did_o    (evt_did_o),
        .evt_pid_o    (evt_pid_o),
        .evt_pid_v_o  (evt_pid_v_o),
        .evt_pscid_o  (evt_pscid_o),
        .evt_gscid_o  (evt_gscid_o),
        .ovf_clr_i    (ovf_clr_i),
        .ovf_o        (ovf_o),
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
        .drop_cnt_o   (drop_cnt_o),
`endif
        .level_o      (level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {mask,did,pid,pid_v,pscid,gscid}, the previous event vector, sticky flag, drop count
    logic [86:0]      m_q[$];
    logic [5:0]       m_prev = '0;
    logic             m_ovf  = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;
    bit               live   = 1'b0;

    always @(posedge clk) begin
        logic [5:0] v, r;
        bit         pop, drop;
        v = {s2_ptw_i, s1_ptw_i, pdt_walk_i, ddt_walk_i, iotlb_miss_i, tr_request_i};
        if (rst_i) begin
            m_q.delete();
            m_prev = '0;
            m_ovf  = 1'b0;
            m_cnt  = '0;
        end else begin
            r    = v & ~m_prev;
            pop  = (m_q.size() > 0) && evt_ready_i;
            drop = (r != 0) && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (r != 0 && !drop) m_q.push_back({r, did_i, pid_i, pid_v_i, pscid_i, gscid_i});
            if (ovf_clr_i) m_cnt = '0;
            if (drop && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            m_ovf  = drop || (m_ovf && !ovf_clr_i);
            m_prev = v;
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("valid", evt_valid_o, m_q.size() != 0);
            chk("level", level_o, m_q.size());
            chk("ovf", ovf_o, m_ovf);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
            chk("drop_cnt", drop_cnt_o, m_cnt);
`endif
            if (m_q.size() != 0)
                chk("head", {evt_mask_o, evt_did_o, evt_pid_o, evt_pid_v_o, evt_pscid_o, evt_gscid_o}, m_q[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input int idx, input logic [23:0] did);
        did_i = did;
        {s2_ptw_i, s1_ptw_i, pdt_walk_i, ddt_walk_i, iotlb_miss_i, tr_request_i} = 6'(1 << idx);
        cyc();
        {s2_ptw_i, s1_ptw_i, pdt_walk_i, ddt_walk_i, iotlb_miss_i, tr_request_i} = '0;
        cyc();
    endtask

    task automatic drain();
        evt_ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
        evt_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        cyc();
        chk("rst_valid", evt_valid_o, 1'b0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_data", {evt_mask_o, evt_did_o, evt_pid_o, evt_pid_v_o, evt_pscid_o, evt_gscid_o}, 0);
        cyc();
        rst_i = 1'b0;
        cyc();

        // single level held for several cycles is one event
        did_i = 24'h00A5A5;
        iotlb_miss_i = 1'b1;
        cyc();
        chk("t1_valid", evt_valid_o, 1'b1);
        chk("t1_mask", evt_mask_o, 6'b000010);
        chk("t1_did", evt_did_o, 24'h00A5A5);
        for (int i = 0; i < 4; i++) cyc();
        chk("t1_level_held", level_o, 1);
        iotlb_miss_i = 1'b0;
        evt_ready_i  = 1'b1;
        cyc();
        evt_ready_i  = 1'b0;
        chk("t1_level_pop", level_o, 0);

        // simultaneous rises share one entry
        gscid_i = 16'h1234;
        s1_ptw_i = 1'b1;
        s2_ptw_i = 1'b1;
        cyc();
        s1_ptw_i = 1'b0;
        s2_ptw_i = 1'b0;
        chk("t2_mask", evt_mask_o, 6'b110000);
        chk("t2_gscid", evt_gscid_o, 16'h1234);
        chk("t2_level", level_o, 1);
        drain();

        // overflow on the fifth entry
        for (int k = 1; k <= 5; k++) pulse(2, 24'(k));
        chk("t3_level", level_o, DEPTH);
        chk("t3_ovf", ovf_o, 1'b1);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
        chk("t3_cnt", drop_cnt_o, 1);
`endif
        evt_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order", evt_did_o, 24'(k));
            cyc();
        end
        evt_ready_i = 1'b0;
        chk("t3_empty", level_o, 0);
        ovf_clr_i = 1'b1;
        cyc();
        ovf_clr_i = 1'b0;
        chk("t3_ovf_clr", ovf_o, 1'b0);

        // full with simultaneous push and pop
        for (int k = 11; k <= 14; k++) pulse(3, 24'(k));
        evt_ready_i = 1'b1;
        did_i = 24'd15;
        pdt_walk_i = 1'b1;
        cyc();
        pdt_walk_i = 1'b0;
        chk("t4_level", level_o, DEPTH);
        chk("t4_ovf", ovf_o, 1'b0);
        for (int k = 12; k <= 15; k++) begin
            chk("t4_order", evt_did_o, 24'(k));
            cyc();
        end
        evt_ready_i = 1'b0;

        // reset mid-operation with a level held across it
        pulse(4, 24'h21);
        pulse(4, 24'h22);
        tr_request_i = 1'b1;
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        chk("t5_flushed", level_o, 0);
        cyc();
        chk("t5_valid", evt_valid_o, 1'b1);
        chk("t5_mask", evt_mask_o, 6'b000001);
        chk("t5_level", level_o, 1);
        tr_request_i = 1'b0;
        drain();

        // overflow clear, then clear coincident with a drop
        for (int k = 1; k <= 5; k++) pulse(1, 24'(k + 40));
        chk("t6_ovf_set", ovf_o, 1'b1);
        ovf_clr_i = 1'b1;
        cyc();
        chk("t6_ovf_clr", ovf_o, 1'b0);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
        chk("t6_cnt_clr", drop_cnt_o, 0);
`endif
        iotlb_miss_i = 1'b1;
        cyc();
        ovf_clr_i = 1'b0;
        iotlb_miss_i = 1'b0;
        chk("t6_ovf_win", ovf_o, 1'b1);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
        chk("t6_cnt_one", drop_cnt_o, 1);
`endif
        drain();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] flip;
            flip = 6'($urandom) & 6'($urandom) & 6'($urandom);
            {s2_ptw_i, s1_ptw_i, pdt_walk_i, ddt_walk_i, iotlb_miss_i, tr_request_i} ^= flip;
            did_i       = 24'($urandom);
            pid_i       = 20'($urandom);
            pid_v_i     = 1'($urandom);
            pscid_i     = 20'($urandom);
            gscid_i     = 16'($urandom);
            evt_ready_i = ($urandom_range(0, 2) != 0) && (i % 400 < 300);
            ovf_clr_i   = ($urandom_range(0, 15) == 0);
            rst_i       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst_i = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
